// File: rtl/gpio_pkg.sv
// GPIO controller shared definitions.
// Register map indices and default port width.
package gpio_pkg;

    localparam int GPIO_N_DEFAULT = 8;

    localparam logic [2:0] ADDR_DATA_OUT   = 3'd0;
    localparam logic [2:0] ADDR_DIR        = 3'd1;
    localparam logic [2:0] ADDR_DATA_IN    = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN    = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN    = 3'd4;
    localparam logic [2:0] ADDR_IRQ_STATUS = 3'd5;
    localparam logic [2:0] ADDR_SET        = 3'd6;
    localparam logic [2:0] ADDR_CLR        = 3'd7;

endpackage

// File: rtl/gpio_in_sync.sv
// Pad input synchroniser with edge history.
// Produces the clean level plus rise/fall pulses.
module gpio_in_sync #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pad_in,
    output logic [N-1:0] sync_in,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                  prev_q;

    // Shift the raw pads through the chain; remember last clean level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign rise    = sync_in & ~prev_q;
    assign fall    = ~sync_in & prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// N-pin GPIO controller: register file, edge IRQs,
// registered read port and pad drive.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int N           = GPIO_N_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pad_in,
    output logic [N-1:0] pad_out,
    output logic [N-1:0] pad_oe,
    input  logic         reg_wr_en,
    input  logic         reg_rd_en,
    input  logic [2:0]   reg_addr,
    input  logic [N-1:0] reg_wdata,
    output logic [N-1:0] reg_rdata,
    output logic         reg_rd_valid,
    output logic         irq
);

    logic [N-1:0] data_out;
    logic [N-1:0] dir;
    logic [N-1:0] rise_en;
    logic [N-1:0] fall_en;
    logic [N-1:0] irq_status;
    logic [N-1:0] sync_in;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] set_mask;
    logic [N-1:0] clr_mask;
    logic [N-1:0] rd_mux;

    gpio_in_sync #(
        .N           (N),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk     (clk),
        .reset   (reset),
        .pad_in  (pad_in),
        .sync_in (sync_in),
        .rise    (rise),
        .fall    (fall)
    );

    // Control registers written by the bus; SET/CLR act on DATA_OUT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            dir      <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
        end else if (reg_wr_en) begin
            unique case (reg_addr)
                ADDR_DATA_OUT: data_out <= reg_wdata;
                ADDR_DIR:      dir      <= reg_wdata;
                ADDR_RISE_EN:  rise_en  <= reg_wdata;
                ADDR_FALL_EN:  fall_en  <= reg_wdata;
                ADDR_SET:      data_out <= data_out | reg_wdata;
                ADDR_CLR:      data_out <= data_out & ~reg_wdata;
                default:       ;
            endcase
        end
    end

    // Edge capture only on input pins; new edges beat W1C
    always_comb begin
        set_mask = ~dir & ((rise & rise_en) | (fall & fall_en));
        clr_mask = '0;
        if (reg_wr_en && (reg_addr == ADDR_IRQ_STATUS))
            clr_mask = reg_wdata;
    end

    // Sticky interrupt status
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irq_status <= '0;
        else
            irq_status <= (irq_status & ~clr_mask) | set_mask;
    end

    // Read mux sees pre-write values; write-only slots read zero
    always_comb begin
        rd_mux = '0;
        unique case (reg_addr)
            ADDR_DATA_OUT:   rd_mux = data_out;
            ADDR_DIR:        rd_mux = dir;
            ADDR_DATA_IN:    rd_mux = sync_in;
            ADDR_RISE_EN:    rd_mux = rise_en;
            ADDR_FALL_EN:    rd_mux = fall_en;
            ADDR_IRQ_STATUS: rd_mux = irq_status;
            default:         rd_mux = '0;
        endcase
    end

    // Registered read port; data holds between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_rdata    <= '0;
            reg_rd_valid <= 1'b0;
        end else begin
            reg_rd_valid <= reg_rd_en;
            if (reg_rd_en)
                reg_rdata <= rd_mux;
        end
    end

    // Registered interrupt line
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= |irq_status;
    end

    assign pad_out = data_out;
    assign pad_oe  = dir;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl.
// Vector table plus hand sequences; reads go via a scoreboard.
module tb_gpio_ctrl;
    import gpio_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] pad_in = '0;
    logic [N-1:0] pad_out;
    logic [N-1:0] pad_oe;
    logic         reg_wr_en = 1'b0;
    logic         reg_rd_en = 1'b0;
    logic [2:0]   reg_addr = '0;
    logic [N-1:0] reg_wdata = '0;
    logic [N-1:0] reg_rdata;
    logic         reg_rd_valid;
    logic         irq;

    int total = 0;
    int bad = 0;

    logic [N-1:0] sb_q[$];
    logic         exp_v = 1'b0;

    typedef struct packed {
        logic         rd;
        logic [2:0]   addr;
        logic [N-1:0] data;
        logic [N-1:0] e_out;
        logic [N-1:0] e_oe;
    } vec_t;

    vec_t vecs[14];

    gpio_ctrl #(.N(N), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .pad_in       (pad_in),
        .pad_out      (pad_out),
        .pad_oe       (pad_oe),
        .reg_wr_en    (reg_wr_en),
        .reg_rd_en    (reg_rd_en),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .reg_rd_valid (reg_rd_valid),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Expected read-valid: one cycle after an accepted strobe
    always @(posedge clk or posedge reset) begin
        if (reset)
            exp_v <= 1'b0;
        else
            exp_v <= reg_rd_en;
    end

    // Scoreboard pop on every read response
    always @(negedge clk) begin
        logic [N-1:0] e;
        if (!reset) begin
            chk("rd_valid", {31'd0, reg_rd_valid}, {31'd0, exp_v});
            if (reg_rd_valid) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rdata_unexpected actual=%h required=none",
                             reg_rdata);
                end else begin
                    e = sb_q.pop_front();
                    chk("rdata", {24'd0, reg_rdata}, {24'd0, e});
                end
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [N-1:0] d);
        @(negedge clk);
        reg_wr_en = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        @(negedge clk);
        reg_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [N-1:0] e);
        @(negedge clk);
        reg_rd_en = 1'b1;
        reg_addr  = a;
        sb_q.push_back(e);
        @(negedge clk);
        reg_rd_en = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, ADDR_DIR,        8'h0F, 8'h00, 8'h0F};
        vecs[1]  = '{1'b0, ADDR_DATA_OUT,   8'hA5, 8'hA5, 8'h0F};
        vecs[2]  = '{1'b0, ADDR_SET,        8'h40, 8'hE5, 8'h0F};
        vecs[3]  = '{1'b0, ADDR_CLR,        8'h01, 8'hE4, 8'h0F};
        vecs[4]  = '{1'b1, ADDR_DATA_OUT,   8'hE4, 8'hE4, 8'h0F};
        vecs[5]  = '{1'b1, ADDR_DIR,        8'h0F, 8'hE4, 8'h0F};
        vecs[6]  = '{1'b1, ADDR_SET,        8'h00, 8'hE4, 8'h0F};
        vecs[7]  = '{1'b1, ADDR_CLR,        8'h00, 8'hE4, 8'h0F};
        vecs[8]  = '{1'b0, ADDR_RISE_EN,    8'h10, 8'hE4, 8'h0F};
        vecs[9]  = '{1'b1, ADDR_RISE_EN,    8'h10, 8'hE4, 8'h0F};
        vecs[10] = '{1'b1, ADDR_FALL_EN,    8'h00, 8'hE4, 8'h0F};
        vecs[11] = '{1'b0, ADDR_DIR,        8'h00, 8'hE4, 8'h00};
        vecs[12] = '{1'b1, ADDR_DATA_IN,    8'hFF, 8'hE4, 8'h00};
        vecs[13] = '{1'b1, ADDR_IRQ_STATUS, 8'h00, 8'hE4, 8'h00};

        // Reset with all pads high
        pad_in = 8'hFF;
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pad_out", {24'd0, pad_out}, 32'h0);
        chk("rst_pad_oe", {24'd0, pad_oe}, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_rd_valid", {31'd0, reg_rd_valid}, 32'h0);

        // Release and read DATA_IN back-to-back
        @(negedge clk);
        reset = 1'b0;
        reg_rd_en = 1'b1;
        reg_addr = ADDR_DATA_IN;
        sb_q.push_back(8'h00);
        @(negedge clk);
        sb_q.push_back(8'h00);
        @(negedge clk);
        sb_q.push_back(8'hFF);
        @(negedge clk);
        reg_rd_en = 1'b0;

        // Table-driven register traffic
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rd) begin
                rd(vecs[i].addr, vecs[i].data);
            end else begin
                wr(vecs[i].addr, vecs[i].data);
                chk($sformatf("v%0d_pad_out", i),
                    {24'd0, pad_out}, {24'd0, vecs[i].e_out});
                chk($sformatf("v%0d_pad_oe", i),
                    {24'd0, pad_oe}, {24'd0, vecs[i].e_oe});
            end
        end

        // Falling edge with FALL_EN=0 sets nothing
        @(negedge clk);
        pad_in = 8'hEF;
        repeat (4) @(negedge clk);
        rd(ADDR_IRQ_STATUS, 8'h00);
        chk("fall_noen_irq", {31'd0, irq}, 32'h0);

        // Rise on pin 4: irq exactly 4 cycles later
        pad_in = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rise_irq_c3", {31'd0, irq}, 32'h0);
        @(negedge clk);
        chk("rise_irq_c4", {31'd0, irq}, 32'h1);
        rd(ADDR_IRQ_STATUS, 8'h10);

        // W1C clears status, irq drops a cycle later
        wr(ADDR_IRQ_STATUS, 8'h10);
        chk("w1c_irq_hold", {31'd0, irq}, 32'h1);
        @(negedge clk);
        chk("w1c_irq_low", {31'd0, irq}, 32'h0);
        rd(ADDR_IRQ_STATUS, 8'h00);

        // Set status again, then W1C collides with a new rise
        pad_in = 8'hEF;
        repeat (4) @(negedge clk);
        pad_in = 8'hFF;
        repeat (4) @(negedge clk);
        chk("rise2_irq", {31'd0, irq}, 32'h1);
        pad_in = 8'hEF;
        repeat (4) @(negedge clk);
        pad_in = 8'hFF;
        @(negedge clk);
        wr(ADDR_IRQ_STATUS, 8'h10);
        chk("coll_irq_a", {31'd0, irq}, 32'h1);
        @(negedge clk);
        chk("coll_irq_b", {31'd0, irq}, 32'h1);
        rd(ADDR_IRQ_STATUS, 8'h10);
        wr(ADDR_IRQ_STATUS, 8'h10);
        repeat (2) @(negedge clk);
        chk("coll_clr_irq", {31'd0, irq}, 32'h0);

        // Output pin edges are ignored
        wr(ADDR_FALL_EN, 8'h04);
        wr(ADDR_DIR, 8'h04);
        chk("dir2_oe", {24'd0, pad_oe}, 32'h04);
        pad_in = 8'hFB;
        repeat (4) @(negedge clk);
        pad_in = 8'hFF;
        repeat (4) @(negedge clk);
        pad_in = 8'hFB;
        repeat (4) @(negedge clk);
        rd(ADDR_IRQ_STATUS, 8'h00);
        chk("out_pin_irq", {31'd0, irq}, 32'h0);

        // Back to input with pad low: no spurious edge
        wr(ADDR_DIR, 8'h00);
        repeat (4) @(negedge clk);
        rd(ADDR_IRQ_STATUS, 8'h00);

        // Real 1->0 on pin 2 now captured
        pad_in = 8'hFF;
        repeat (4) @(negedge clk);
        rd(ADDR_IRQ_STATUS, 8'h00);
        pad_in = 8'hFB;
        repeat (4) @(negedge clk);
        rd(ADDR_IRQ_STATUS, 8'h04);
        chk("fall2_irq", {31'd0, irq}, 32'h1);

        // Asynchronous reset mid-operation
        wr(ADDR_DATA_OUT, 8'h3C);
        chk("pre_rst_out", {24'd0, pad_out}, 32'h3C);
        chk("pre_rst_irq", {31'd0, irq}, 32'h1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_pad_out", {24'd0, pad_out}, 32'h0);
        chk("arst_pad_oe", {24'd0, pad_oe}, 32'h0);
        chk("arst_irq", {31'd0, irq}, 32'h0);
        chk("arst_rdata", {24'd0, reg_rdata}, 32'h0);
        chk("arst_rd_valid", {31'd0, reg_rd_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
